// File: rtl/alu_muldiv_seq.sv
// ============================================================================
//  Module      : alu_muldiv_seq
//  Description : Multi-cycle sequencer that borrows the shared add/sub ALU to
//                run shift-add unsigned multiply (low half) and restoring
//                shift-subtract unsigned divide / remainder, one ALU pass per
//                iteration. Optional build macro ALU_MULDIV_EARLY_OUT_EN lets
//                MUL finish as soon as the remaining multiplier bits are zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_muldiv_seq #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  output logic             alu_sub,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // FSM state
  logic [1:0]       state_q, state_d;

  // Latched operation and iteration counter
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Multiply datapath: accumulator, shifting multiplicand and multiplier
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;

  // Divide datapath: partial remainder, dividend/quotient shifter, divisor
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;

  // Registered outputs
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  // Decoded helpers
  logic             is_div_q;
  logic             start_is_div;
  logic             start_div0;
  logic             last_iter;
  logic             early_out;
  logic [WIDTH-1:0] shifted;
  logic             take;

  assign is_div_q     = (op_q == OP_DIVU) || (op_q == OP_REMU);
  assign start_is_div = (op == OP_DIVU) || (op == OP_REMU);
  assign start_div0   = start_is_div && (rs2 == '0);
  assign last_iter    = (cnt_q == CNT_LAST);

  // Divide step: shift in next dividend bit, subtract divisor when it fits.
  // A set remainder MSB means the shifted value needs WIDTH+1 bits and is
  // therefore certainly >= divisor, even though the ALU sees it truncated.
  assign shifted = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  assign take    = alu_carry || rem_q[WIDTH-1];

`ifdef ALU_MULDIV_EARLY_OUT_EN
  // Multiplier exhausted: accumulator is already final, stop iterating.
  assign early_out = (state_q == ST_RUN) && !is_div_q && (mplier_q == '0);
`else
  assign early_out = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = start_div0 ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (early_out || last_iter) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: busy flag and ALU operand/control drive
  always_comb begin
    busy    = (state_q != ST_IDLE);
    alu_sel = 3'b000;
    alu_a   = '0;
    alu_b   = '0;
    alu_sub = 1'b0;
    if (state_q == ST_RUN) begin
      if (is_div_q) begin
        alu_a   = shifted;
        alu_b   = divisor_q;
        alu_sub = 1'b1;
      end else begin
        alu_a   = acc_q;
        alu_b   = mcand_q;
        alu_sub = 1'b0;
      end
    end
  end

  // Datapath next-state: operand capture, per-iteration update, result
  always_comb begin
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d      = op;
          cnt_d     = '0;
          acc_d     = '0;
          mcand_d   = rs1;
          mplier_d  = rs2;
          rem_d     = '0;
          dvd_d     = rs1;
          divisor_d = rs2;
          if (start_div0) begin
            // Divide by zero: quotient all ones, remainder is the dividend
            result_d = (op == OP_DIVU) ? '1 : rs1;
            done_d   = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (!early_out) begin
          if (is_div_q) begin
            rem_d = take ? alu_out : shifted;
            dvd_d = {dvd_q[WIDTH-2:0], take};
          end else begin
            if (mplier_q[0]) begin
              acc_d = alu_out;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
          end
          cnt_d = cnt_q + 1'b1;
        end
        if (early_out || last_iter) begin
          // Result includes this cycle's iteration
          done_d = 1'b1;
          if (op_q == OP_DIVU) begin
            result_d = dvd_d;
          end else if (op_q == OP_REMU) begin
            result_d = rem_d;
          end else begin
            result_d = acc_d;
          end
        end
      end

      default: begin
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
// ============================================================================
//  Module      : tb_alu_muldiv_seq
//  Description : Self-checking bench for alu_muldiv_seq. Models the shared
//                add/sub ALU, runs directed and randomized MUL/DIVU/REMU
//                operations and compares result and latency against plain
//                arithmetic. Honours ALU_MULDIV_EARLY_OUT_EN for latency.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_muldiv_seq;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs1;
  logic [W-1:0] rs2;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_sel;
  logic         alu_sub;
  logic [W-1:0] alu_out;
  logic         alu_carry;

  int total;
  int bad;

  alu_muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .rs1      (rs1),
    .rs2      (rs2),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_sub  (alu_sub),
    .alu_out  (alu_out),
    .alu_carry(alu_carry)
  );

  // Shared ALU: add, or subtract as A + ~B + 1 with carry meaning no borrow
  logic [W:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    if (alu_sub) begin
      alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, 1'b1};
    end else begin
      alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    end
  end
  assign alu_out   = alu_sum[W-1:0];
  assign alu_carry = alu_sum[W];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result from plain arithmetic
  function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    logic [W-1:0] r;
    if (o == 2'b01) begin
      r = (b == 0) ? {W{1'b1}} : a / b;
    end else if (o == 2'b10) begin
      r = (b == 0) ? a : a % b;
    end else begin
      r = a * b;
    end
    return r;
  endfunction

  // Clock edges from the accepting edge up to and including the DONE edge
  function automatic int ref_edges(input logic [1:0] o, input logic [W-1:0] b);
    int e;
    e = W + 1;
    if ((o == 2'b01 || o == 2'b10) && b == 0) begin
      e = 1;
    end
`ifdef ALU_MULDIV_EARLY_OUT_EN
    if (o == 2'b00 || o == 2'b11) begin
      int hi;
      hi = -1;
      for (int i = 0; i < W; i++) begin
        if (b[i]) hi = i;
      end
      e = (hi + 3 < W + 1) ? hi + 3 : W + 1;
    end
`endif
    return e;
  endfunction

  // Issue one operation, optionally pulse start mid-run, and check it
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inject_at, input string tag);
    int           edges;
    logic         busy_ok;
    logic         x_ok;
    logic [W-1:0] expv;
    expv = ref_result(o, a, b);
    @(negedge clk);
    op    = o;
    rs1   = a;
    rs2   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    edges   = 1;
    busy_ok = 1'b1;
    x_ok    = 1'b1;
    while (!done && edges < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if ($isunknown({alu_a, alu_b, alu_sub, alu_sel})) x_ok = 1'b0;
      if (edges == inject_at) begin
        op    = ~o;
        rs1   = {$urandom, $urandom};
        rs2   = 64'd3;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      edges++;
    end
    chk({tag, ":latency"}, W'(edges), W'(ref_edges(o, b)));
    chk({tag, ":result"}, result, expv);
    chk({tag, ":busy_run"}, W'(busy_ok), W'(1));
    chk({tag, ":busy_done"}, W'(busy), W'(1));
    chk({tag, ":alu_no_x"}, W'(x_ok), W'(1));
    // start presented during DONE must be ignored
    op    = 2'b01;
    rs1   = {$urandom, $urandom};
    rs2   = 64'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, ":idle_busy"}, W'(busy), W'(0));
    chk({tag, ":idle_done"}, W'(done), W'(0));
    chk({tag, ":held"}, result, expv);
  endtask

  initial begin
    int           inj;
    logic [1:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    rs1   = '0;
    rs2   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:busy", W'(busy), W'(0));
    chk("rst:done", W'(done), W'(0));
    chk("rst:result", result, '0);
    chk("rst:alu", alu_a | alu_b | W'(alu_sub) | W'(alu_sel), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(2'b00, 64'd15, 64'd3, 0, "mul_15x3");
    run_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, "mul_wrap");
    run_op(2'b01, 64'd100, 64'd7, 0, "divu_100_7");
    run_op(2'b10, 64'd100, 64'd7, 0, "remu_100_7");
    run_op(2'b01, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 0, "divu_msb");
    run_op(2'b10, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 0, "remu_msb");
    run_op(2'b01, 64'd5, 64'd0, 0, "divu_by0");
    run_op(2'b10, 64'd5, 64'd0, 0, "remu_by0");
    run_op(2'b11, 64'd7, 64'd9, 0, "op11_mul");
    run_op(2'b00, 64'd1234, 64'd0, 0, "mul_by0");
    run_op(2'b00, 64'd1234, 64'd1, 0, "mul_by1");

    // Asynchronous reset in the middle of a MUL
    @(negedge clk);
    op    = 2'b00;
    rs1   = 64'd3;
    rs2   = 64'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst:busy", W'(busy), W'(0));
    chk("midrst:done", W'(done), W'(0));
    chk("midrst:result", result, '0);
    chk("midrst:alu", alu_a | alu_b | W'(alu_sub), '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b00, 64'd3, 64'd4, 10, "mul_after_rst");

    // Randomized operations against the arithmetic reference
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0:       rb = {$urandom, $urandom};
        1:       rb = 64'($urandom_range(0, 15));
        2:       rb = 64'd0;
        3:       rb = {1'b1, 31'($urandom), 32'($urandom)};
        default: rb = 64'($urandom);
      endcase
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 50)) : 0;
      run_op(ro, ra, rb, inj, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
